// File: rtl/riscv_core_dcache_refill_unit.sv
// Data-cache line-fill engine.
// On a miss it issues one INCR AXI4 read burst for the line-aligned address.
// It packs the returned beats into one cache block and then pulses either
// block-valid or refill-error for a single cycle.
// Only one refill is in flight at a time. Beats return in address order
// (no critical-word-first).
module riscv_core_dcache_refill_unit #(
  parameter int ADDR_WIDTH     = 64,
  parameter int BLOCK_WIDTH    = 256,
  parameter int AXI_BEAT_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ID         = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_refill_req,
  input  logic [ADDR_WIDTH-1:0]     i_refill_addr,
  output logic                      o_refill_busy,
  output logic [BLOCK_WIDTH-1:0]    o_block,
  output logic [ADDR_WIDTH-1:0]     o_block_addr,
  output logic                      o_block_valid,
  output logic                      o_refill_err,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  output logic [ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  output logic [AXI_ID_WIDTH-1:0]   o_arid,
  input  logic                      i_rvalid,
  output logic                      o_rready,
  input  logic [AXI_BEAT_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast,
  input  logic [AXI_ID_WIDTH-1:0]   i_rid
);

  localparam int BEATS = BLOCK_WIDTH / AXI_BEAT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(BLOCK_WIDTH / 8);
  localparam logic [CNT_W-1:0]        LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0]   OFF_MASK  = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
  localparam logic [AXI_ID_WIDTH-1:0] OWN_ID    = AXI_ID_WIDTH'(AXI_ID);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    err_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [BLOCK_WIDTH-1:0]  block_q;
  logic                    beat_acc;
  logic                    beat_final;
  logic                    beat_bad;

  // rready is held high for the whole DATA state, so every valid beat is taken.
  assign beat_acc   = (state == S_DATA) && i_rvalid;
  assign beat_final = (beat_cnt == LAST_BEAT);
  // A beat is bad on an error response or a foreign ID. It is also bad when
  // rlast disagrees with the beat count: set too early, or missing on the last beat.
  assign beat_bad   = (i_rresp != 2'b00) || (i_rid != OWN_ID) || (i_rlast != beat_final);

  assign o_araddr     = addr_q;
  assign o_block_addr = addr_q;
  assign o_block      = block_q;
  assign o_arlen      = 8'(BEATS - 1);
  assign o_arsize     = 3'($clog2(AXI_BEAT_WIDTH / 8));
  assign o_arburst    = 2'b01;
  assign o_arid       = OWN_ID;

  // State register; reset abandons any burst in flight (fabric shares the reset).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and handshake/pulse decode.
  always_comb begin
    state_nxt     = state;
    o_refill_busy = 1'b1;
    o_arvalid     = 1'b0;
    o_rready      = 1'b0;
    o_block_valid = 1'b0;
    o_refill_err  = 1'b0;
    case (state)
      S_IDLE: begin
        o_refill_busy = 1'b0;
        if (i_refill_req) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        o_arvalid = 1'b1;
        if (i_arready) state_nxt = S_DATA;
      end
      S_DATA: begin
        o_rready = 1'b1;
        // An early rlast also ends the burst; the error flag records it.
        if (i_rvalid && (beat_final || i_rlast)) state_nxt = S_DONE;
      end
      S_DONE: begin
        o_block_valid = !err_q;
        o_refill_err  = err_q;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture line address on request; pack beats into their slots and track errors.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q   <= '0;
      block_q  <= '0;
      err_q    <= 1'b0;
      beat_cnt <= '0;
    end else if ((state == S_IDLE) && i_refill_req) begin
      addr_q   <= i_refill_addr & ~OFF_MASK;
      block_q  <= '0;
      err_q    <= 1'b0;
      beat_cnt <= '0;
    end else if (beat_acc) begin
      for (int i = 0; i < BEATS; i++) begin
        if (beat_cnt == CNT_W'(i)) block_q[i*AXI_BEAT_WIDTH +: AXI_BEAT_WIDTH] <= i_rdata;
      end
      beat_cnt <= beat_cnt + 1'b1;
      err_q    <= err_q | beat_bad;
    end
  end

endmodule

// File: tb/tb_riscv_core_dcache_refill_unit.sv
// Bench for the dcache refill unit. It runs a table of directed refills,
// then a mid-burst reset, then randomized refills.
// Expected results come from the bench's own line-fill model.
module tb_riscv_core_dcache_refill_unit;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0;
  logic [63:0]  addr = '0;
  logic         busy;
  logic [255:0] block;
  logic [63:0]  block_addr;
  logic         blk_valid, ref_err;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [3:0]   arid;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [63:0]  rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0;
  logic [3:0]   rid = '0;

  int checks = 0;
  int errors = 0;
  int ar_hs  = 0;

  always #5 clk = ~clk;

  riscv_core_dcache_refill_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_refill_req(req), .i_refill_addr(addr),
    .o_refill_busy(busy), .o_block(block), .o_block_addr(block_addr),
    .o_block_valid(blk_valid), .o_refill_err(ref_err),
    .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr), .o_arlen(arlen),
    .o_arsize(arsize), .o_arburst(arburst), .o_arid(arid),
    .i_rvalid(rvalid), .o_rready(rready), .i_rdata(rdata), .i_rresp(rresp),
    .i_rlast(rlast), .i_rid(rid)
  );

  // Count AR handshakes seen by the fabric.
  always @(posedge clk) if (arvalid && arready) ar_hs <= ar_hs + 1;

  // gap[2k+:2] = idle cycles before beat k, resp[2k+:2] = response of beat k,
  // last[k]/badid[k] = rlast / foreign RID on beat k.
  typedef struct packed {
    logic [63:0] addr;
    logic [1:0]  ar_wait;
    logic [7:0]  gap;
    logic [7:0]  resp;
    logic [3:0]  last;
    logic [3:0]  badid;
    logic        req_hold;
    logic        exp_err;
    logic [63:0] exp_araddr;
  } vec_t;

  localparam logic [63:0] P1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] P2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] P3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] P4 = 64'h4444_4444_4444_4444;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Number of beats the slave sends: up to and including the first rlast, at most 4.
  function automatic int beats_sent(input vec_t v);
    for (int i = 0; i < 4; i++) if (v.last[i]) return i + 1;
    return 4;
  endfunction

  // A refill fails if any sent beat is bad, or if rlast is not exactly on beat 4.
  function automatic logic model_err(input vec_t v);
    int nb = beats_sent(v);
    for (int i = 0; i < nb; i++)
      if (v.resp[2*i +: 2] != 2'b00 || v.badid[i] || (v.last[i] != (i == 3))) return 1'b1;
    if (nb != 4) return 1'b1;
    return 1'b0;
  endfunction

  // Run one refill starting in an IDLE cycle (called at posedge+1).
  // If rst_after > 0, reset is asserted after that many beats instead of completing.
  task automatic run_refill(input vec_t v, input logic [63:0] d0, input logic [63:0] d1,
                            input logic [63:0] d2, input logic [63:0] d3, input int rst_after);
    logic [63:0] d[4];
    int nb, hs0;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    nb = beats_sent(v);
    req = 1'b1; addr = v.addr;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_pulses", {blk_valid, ref_err}, 0);
    hs0 = ar_hs;
    @(posedge clk); #1;
    if (!v.req_hold) req = 1'b0;
    for (int w = 0; w <= int'(v.ar_wait); w++) begin
      arready = (w == int'(v.ar_wait));
      @(negedge clk);
      chk("ar_valid", arvalid, 1);
      chk("ar_addr", araddr, v.exp_araddr);
      chk("ar_fields", {arlen, arsize, arburst, arid}, {8'd3, 3'd3, 2'd1, 4'd0});
      chk("ar_busy", busy, 1);
      @(posedge clk); #1;
    end
    arready = 1'b0;
    for (int k = 0; k < nb; k++) begin
      for (int g = 0; g < int'(v.gap[2*k +: 2]); g++) begin
        rvalid = 1'b0;
        @(negedge clk);
        chk("gap_rready", rready, 1);
        chk("gap_busy_ar", {busy, arvalid}, 2'b10);
        chk("gap_pulses", {blk_valid, ref_err}, 0);
        @(posedge clk); #1;
      end
      rvalid = 1'b1; rdata = d[k]; rresp = v.resp[2*k +: 2];
      rlast = v.last[k]; rid = v.badid[k] ? 4'h5 : 4'h0;
      if (k == nb - 1) req = 1'b0;
      @(negedge clk);
      chk("beat_rready", rready, 1);
      chk("beat_pulses", {blk_valid, ref_err}, 0);
      @(posedge clk); #1;
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rid = 4'h0;
      if (rst_after == k + 1) begin
        rst_n = 1'b0;
        #1;
        chk("rst_ctrl", {busy, arvalid, rready, blk_valid, ref_err}, 0);
        chk("rst_block", block, 0);
        chk("rst_addr", {block_addr, araddr}, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
    end
    @(negedge clk);
    chk("done_valid", blk_valid, !v.exp_err);
    chk("done_err", ref_err, v.exp_err);
    chk("done_busy", busy, 1);
    chk("ar_count", ar_hs - hs0, 1);
    chk("done_baddr", block_addr, v.exp_araddr);
    if (!v.exp_err) chk("done_block", block, {d[3], d[2], d[1], d[0]});
    @(posedge clk); #1;
  endtask

  vec_t tbl[9];
  vec_t rv;
  logic [63:0] r0, r1, r2, r3;

  initial begin
    // addr, wait, gap, resp, last, badid, hold, err, araddr
    tbl[0] = '{64'h0000_0000_8000_1234, 2'd0, 8'h00, 8'h00, 4'b1000, 4'b0000, 1'b0, 1'b0, 64'h0000_0000_8000_1220};
    tbl[1] = '{64'h0000_0000_8000_1234, 2'd3, 8'h00, 8'h00, 4'b1000, 4'b0000, 1'b0, 1'b0, 64'h0000_0000_8000_1220};
    tbl[2] = '{64'h0000_0000_8000_1234, 2'd0, 8'h60, 8'h00, 4'b1000, 4'b0000, 1'b0, 1'b0, 64'h0000_0000_8000_1220};
    tbl[3] = '{64'h0000_0000_8000_1234, 2'd0, 8'h00, 8'h08, 4'b1000, 4'b0000, 1'b0, 1'b1, 64'h0000_0000_8000_1220};
    tbl[4] = '{64'h1234_5678_9ABC_DEFF, 2'd1, 8'h00, 8'h00, 4'b1000, 4'b0000, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEE0};
    tbl[5] = '{64'h0000_0000_8000_1234, 2'd0, 8'h00, 8'h00, 4'b0010, 4'b0000, 1'b1, 1'b1, 64'h0000_0000_8000_1220};
    tbl[6] = '{64'h0000_0000_0000_003F, 2'd0, 8'h00, 8'h00, 4'b1000, 4'b0100, 1'b0, 1'b1, 64'h0000_0000_0000_0020};
    tbl[7] = '{64'h0000_0000_0000_0040, 2'd2, 8'h00, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b1, 64'h0000_0000_0000_0040};
    tbl[8] = '{64'hFFFF_FFFF_FFFF_FFE0, 2'd1, 8'h55, 8'h00, 4'b1000, 4'b0000, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFE0};

    #3;
    chk("reset_ctrl", {busy, arvalid, rready, blk_valid, ref_err}, 0);
    chk("reset_block", block, 0);
    chk("reset_addr", {block_addr, araddr}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 9; t++) run_refill(tbl[t], P1, P2, P3, P4, 0);

    // Held values after DONE, then a quiet idle cycle.
    @(negedge clk);
    chk("hold_block", block, {P4, P3, P2, P1});
    chk("hold_baddr", block_addr, 64'hFFFF_FFFF_FFFF_FFE0);
    chk("hold_idle", {busy, arvalid, blk_valid, ref_err}, 0);
    @(posedge clk); #1;

    // Reset after two beats, then a clean full refill.
    run_refill(tbl[0], P4, P3, P2, P1, 2);
    run_refill(tbl[4], P1, P2, P3, P4, 0);

    // Randomized refills checked against the model.
    for (int n = 0; n < 40; n++) begin
      rv.addr     = {$urandom, $urandom};
      rv.ar_wait  = 2'($urandom_range(0, 3));
      rv.gap      = 8'($urandom);
      rv.resp     = ($urandom_range(0, 7) == 0) ? 8'(2'($urandom_range(1, 3)) << (2 * $urandom_range(0, 3))) : 8'h00;
      case ($urandom_range(0, 7))
        0:       rv.last = 4'b0001 << $urandom_range(0, 2);
        1:       rv.last = 4'b0000;
        default: rv.last = 4'b1000;
      endcase
      rv.badid      = ($urandom_range(0, 9) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      rv.req_hold   = 1'($urandom_range(0, 1));
      rv.exp_err    = model_err(rv);
      rv.exp_araddr = rv.addr & ~64'h1F;
      r0 = {$urandom, $urandom}; r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom}; r3 = {$urandom, $urandom};
      run_refill(rv, r0, r1, r2, r3, 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
